// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: turns a received UART byte stream into register-file accesses.
//   Write frame: 0xAA, addr, data  -> one WrEn pulse with Address/WrData.
//   Read frame : 0xBB, addr        -> one RdEn pulse, then the returned RdData
//                                     is pushed to the TX FIFO (TX_D_VLD pulse).
// Ports:
//   CLK, RST (async, active-low)
//   RX_P_DATA/RX_D_VLD        : received byte and its strobe
//   Address/WrEn/RdEn/WrData  : register file request side
//   RdData/RdData_valid       : register file response side
//   TX_P_DATA/TX_D_VLD        : byte and write strobe to the TX FIFO
//   TX_FIFO_FULL              : TX FIFO back-pressure
//   Frame_Err                 : one-cycle pulse when a frame is aborted
// Build option: define RF_CMD_TIMEOUT_EN to abort a frame when the gap between
// its bytes reaches TIMEOUT_CYCLES; otherwise the controller waits forever and
// Frame_Err is constant 0.
module rf_cmd_ctrl #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_valid,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_FIFO_FULL,
   output logic                  Frame_Err
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

   // A zero gap limit would abort every frame before its first operand byte.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("rf_cmd_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_t;

   state_t state;

   // States in which the controller is waiting for the next byte of a frame.
   logic in_gap_state;
   assign in_gap_state = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);

`ifdef RF_CMD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] gap_cnt;
   logic             gap_expired;

   // The counter value TIMEOUT_CYCLES-1 marks the last byte-less cycle allowed.
   assign gap_expired = (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign Frame_Err = 1'b0;
`endif

   // Frame parser with registered strobes and data outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         Address   <= '0;
         WrData    <= '0;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
`ifdef RF_CMD_TIMEOUT_EN
         Frame_Err <= 1'b0;
         gap_cnt   <= '0;
`endif
      end else begin
         // Strobes are single-cycle pulses unless re-asserted below.
         WrEn     <= 1'b0;
         RdEn     <= 1'b0;
         TX_D_VLD <= 1'b0;
`ifdef RF_CMD_TIMEOUT_EN
         Frame_Err <= 1'b0;
         gap_cnt   <= '0;
`endif

         case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_WR) begin
                     state <= WR_ADDR;
                  end else if (RX_P_DATA == CMD_RD) begin
                     state <= RD_ADDR;
                  end
               end
            end

            WR_ADDR: begin
               if (RX_D_VLD) begin
                  Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  state   <= WR_DATA;
               end
            end

            WR_DATA: begin
               if (RX_D_VLD) begin
                  WrData <= RX_P_DATA;
                  WrEn   <= 1'b1;
                  state  <= IDLE;
               end
            end

            RD_ADDR: begin
               if (RX_D_VLD) begin
                  Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  RdEn    <= 1'b1;
                  state   <= RD_WAIT;
               end
            end

            // Received bytes are dropped while a read is in flight.
            RD_WAIT: begin
               if (RdData_valid) begin
                  TX_P_DATA <= RdData;
                  state     <= TX_SEND;
               end
            end

            TX_SEND: begin
               if (!TX_FIFO_FULL) begin
                  TX_D_VLD <= 1'b1;
                  state    <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase

`ifdef RF_CMD_TIMEOUT_EN
         // A byte on the terminal cycle wins over the abort (handled above).
         if (in_gap_state && !RX_D_VLD) begin
            if (gap_expired) begin
               state     <= IDLE;
               Frame_Err <= 1'b1;
            end else begin
               gap_cnt <= gap_cnt + CNT_W'(1);
            end
         end
`endif
      end
   end

`ifndef RF_CMD_TIMEOUT_EN
   // Without the timeout the gap states simply wait; nothing depends on this.
   logic unused_gap;
   assign unused_gap = in_gap_state;
`endif

endmodule
